// File: rtl/wb_flags_stage.sv
// ============================================================================
// wb_flags_stage : writeback FIFO, register-file drain, committed C/Z/N flags
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_flags_stage #(
  parameter int DEPTH = 2,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd_addr,
  input  logic [DW-1:0] in_rd_data,
  input  logic          in_rd_we,
  input  logic          in_flag_we,
  input  logic          in_carry,
  input  logic          in_zero,
  input  logic          in_neg,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic          rf_ready,
  output logic          carry_q,
  output logic          zero_q,
  output logic          neg_q,
  output logic          flag_pending,
  input  logic [AW-1:0] byp_addr,
  output logic          byp_hit,
  output logic [DW-1:0] byp_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic          we_mem   [DEPTH];
  logic          fwe_mem  [DEPTH];
  logic [2:0]    flg_mem  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          head_valid;
  logic          push;
  logic          retire;

  assign head_valid = (count != '0);
  assign in_ready   = !rst && !flush && (count < CW'(DEPTH));
  assign push       = in_valid && in_ready;
  // Entries without a register write never wait on the port.
  assign retire     = head_valid && !rst && !flush && (rf_ready || !we_mem[rd_ptr]);

  assign rf_we    = head_valid && !rst && !flush && we_mem[rd_ptr];
  assign rf_waddr = head_valid ? addr_mem[rd_ptr] : '0;
  assign rf_wdata = head_valid ? data_mem[rd_ptr] : '0;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    byp_hit      = 1'b0;
    byp_data     = '0;
    flag_pending = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (fwe_mem[idx])
          flag_pending = 1'b1;
        if (we_mem[idx] && (addr_mem[idx] == byp_addr)) begin
          byp_hit  = 1'b1;
          byp_data = data_mem[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_rd_addr;
      data_mem[wr_ptr] <= in_rd_data;
      we_mem[wr_ptr]   <= in_rd_we;
      fwe_mem[wr_ptr]  <= in_flag_we;
      flg_mem[wr_ptr]  <= {in_carry, in_zero, in_neg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (retire) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (fwe_mem[rd_ptr])
          {carry_q, zero_q, neg_q} <= flg_mem[rd_ptr];
      end
      case ({push, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_flags_stage.sv
// Directed bench for wb_flags_stage: push/drain, back-pressure, bypass, flags, flush, reset.
`default_nettype none

module tb_wb_flags_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  in_rd_addr;
  logic [31:0] in_rd_data;
  logic        in_rd_we, in_flag_we, in_carry, in_zero, in_neg;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready, carry_q, zero_q, neg_q, flag_pending;
  logic [3:0]  byp_addr;
  logic        byp_hit;
  logic [31:0] byp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_flags_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .in_rd_we(in_rd_we), .in_flag_we(in_flag_we),
    .in_carry(in_carry), .in_zero(in_zero), .in_neg(in_neg),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .carry_q(carry_q), .zero_q(zero_q), .neg_q(neg_q),
    .flag_pending(flag_pending),
    .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d,
                       input logic we, input logic fwe, input logic c, input logic z, input logic n);
    in_valid   = v;
    in_rd_addr = a;
    in_rd_data = d;
    in_rd_we   = we;
    in_flag_we = fwe;
    in_carry   = c;
    in_zero    = z;
    in_neg     = n;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rf_ready = 1'b0; byp_addr = 4'd0;
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_flags", {29'd0, carry_q, zero_q, neg_q}, 32'd0);
    chk("rst_pending", {31'd0, flag_pending}, 32'd0);
    chk("rst_byp_hit", {31'd0, byp_hit}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic push and drain with flag commit
    rf_ready = 1'b1;
    drive(1'b1, 4'd3, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_rf_we", {31'd0, rf_we}, 32'd1);
    chk("t1_waddr", {28'd0, rf_waddr}, 32'd3);
    chk("t1_wdata", rf_wdata, 32'h12345678);
    chk("t1_flags_hold", {29'd0, carry_q, zero_q, neg_q}, 32'd0);
    chk("t1_pending", {31'd0, flag_pending}, 32'd1);
    step();
    chk("t1_flags", {29'd0, carry_q, zero_q, neg_q}, 32'b100);
    chk("t1_rf_we_off", {31'd0, rf_we}, 32'd0);
    chk("t1_pending_off", {31'd0, flag_pending}, 32'd0);

    // Back-pressure: fill, hold a third result, then drain
    rf_ready = 1'b0;
    drive(1'b1, 4'd1, 32'h111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd2, 32'h222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_ready_cnt1", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b1, 4'd4, 32'h444, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_head_addr", {28'd0, rf_waddr}, 32'd1);
    step();
    chk("t2_still_full", {31'd0, in_ready}, 32'd0);
    chk("t2_head_data", rf_wdata, 32'h111);
    rf_ready = 1'b1;
    step();
    chk("t2_head_b", rf_wdata, 32'h222);
    chk("t2_ready_after", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_head_c_addr", {28'd0, rf_waddr}, 32'd4);
    chk("t2_head_c_data", rf_wdata, 32'h444);
    chk("t2_head_c_we", {31'd0, rf_we}, 32'd1);
    step();
    chk("t2_drained", {31'd0, rf_we}, 32'd0);
    chk("t2_flags_kept", {29'd0, carry_q, zero_q, neg_q}, 32'b100);

    // Bypass: youngest of two writes to R5 wins
    rf_ready = 1'b0;
    drive(1'b1, 4'd5, 32'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd5, 32'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    byp_addr = 4'd5;
    #1;
    chk("t3_byp_hit", {31'd0, byp_hit}, 32'd1);
    chk("t3_byp_data", byp_data, 32'hB);
    byp_addr = 4'd6;
    #1;
    chk("t3_byp_miss", {31'd0, byp_hit}, 32'd0);
    chk("t3_byp_miss_data", byp_data, 32'd0);

    // Flush of a full FIFO while the port is free
    rf_ready = 1'b1; flush = 1'b1; byp_addr = 4'd5;
    #1;
    chk("t5_flush_rf_we", {31'd0, rf_we}, 32'd0);
    chk("t5_flush_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("t5_ready_after", {31'd0, in_ready}, 32'd1);
    chk("t5_empty_we", {31'd0, rf_we}, 32'd0);
    chk("t5_empty_byp", {31'd0, byp_hit}, 32'd0);
    chk("t5_flags_kept", {29'd0, carry_q, zero_q, neg_q}, 32'b100);

    // S=1 then S=0: only the first commits
    rf_ready = 1'b0;
    drive(1'b1, 4'd7, 32'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd8, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_push_no_flag", {29'd0, carry_q, zero_q, neg_q}, 32'b100);
    chk("t4_pending", {31'd0, flag_pending}, 32'd1);
    rf_ready = 1'b1;
    step();
    chk("t4_commit", {29'd0, carry_q, zero_q, neg_q}, 32'b010);
    chk("t4_pending_off", {31'd0, flag_pending}, 32'd0);
    step();
    chk("t4_unchanged", {29'd0, carry_q, zero_q, neg_q}, 32'b010);

    // rd_we=0 entry retires without rf_ready
    rf_ready = 1'b0;
    drive(1'b1, 4'd9, 32'h9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_no_write", {31'd0, rf_we}, 32'd0);
    step();
    chk("t6_flags", {29'd0, carry_q, zero_q, neg_q}, 32'b111);
    chk("t6_pending_off", {31'd0, flag_pending}, 32'd0);

    // R15 bypass plus reset with two entries pending
    drive(1'b1, 4'd15, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 4'd11, 32'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    byp_addr = 4'd15;
    #1;
    chk("t7_byp_r15", byp_data, 32'h55);
    rf_ready = 1'b1; rst = 1'b1;
    #1;
    chk("t7_rst_no_write", {31'd0, rf_we}, 32'd0);
    chk("t7_rst_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t7_flags_clr", {29'd0, carry_q, zero_q, neg_q}, 32'd0);
    chk("t7_byp_clr", {31'd0, byp_hit}, 32'd0);
    chk("t7_we_clr", {31'd0, rf_we}, 32'd0);
    chk("t7_pending_clr", {31'd0, flag_pending}, 32'd0);
    chk("t7_ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
